// File: rtl/pair_sort_sequencer.sv
// Job controller feeding value pairs from a source FIFO into the 2-value sorter and
// merging sorter output with an odd-tail bypass. Optional stats: PAIR_SORT_STATS_EN.
module pair_sort_sequencer #(
    parameter int LEN_W = 8,
    parameter int DW    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [LEN_W-1:0] len,
    input  logic             src_empty,
    input  logic [DW-1:0]    src_data,
    output logic             src_pop_n,
    input  logic             dst_room2,
    output logic             sort_start,
    output logic [DW-1:0]    sort_a,
    output logic [DW-1:0]    sort_b,
    input  logic [DW-1:0]    sort_data,
    input  logic             sort_push_n,
    output logic [DW-1:0]    dst_data,
    output logic             dst_push_n,
    output logic             busy,
    output logic             done,
`ifdef PAIR_SORT_STATS_EN
    output logic [LEN_W-1:0] pair_cnt,
    output logic             tail_seen,
`endif
    output logic             err
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH_A   = 4'd1,
        FETCH_B   = 4'd2,
        WAIT_ROOM = 4'd3,
        START     = 4'd4,
        DRAIN1    = 4'd5,
        DRAIN2    = 4'd6,
        TAIL      = 4'd7,
        DONE      = 4'd8
    } state_t;

    state_t           state_r, state_next;
    logic [LEN_W-1:0] remaining_r, remaining_next;
    logic [DW-1:0]    sort_a_r, sort_a_next;
    logic [DW-1:0]    sort_b_r, sort_b_next;
    logic             err_r, err_next;
    logic             sort_start_r, busy_r, done_r;
    logic             go_accept_s, tail_pop_s;
    logic [LEN_W-1:0] remaining_dec_s;

    // Saturating decrement so the element counter can never wrap below zero.
    assign remaining_dec_s = (remaining_r == '0) ? '0 : remaining_r - LEN_W'(1);

    // Next-state, datapath capture and the combinational FIFO/sorter handshakes.
    always_comb begin
        state_next     = state_r;
        remaining_next = remaining_r;
        sort_a_next    = sort_a_r;
        sort_b_next    = sort_b_r;
        err_next       = err_r;
        src_pop_n      = 1'b1;
        dst_push_n     = 1'b1;
        dst_data       = '0;
        go_accept_s    = 1'b0;
        tail_pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (go) begin
                    go_accept_s    = 1'b1;
                    remaining_next = len;
                    err_next       = 1'b0;
                    if (len == '0) begin
                        state_next = DONE;
                    end else if (len == LEN_W'(1)) begin
                        state_next = TAIL;
                    end else begin
                        state_next = FETCH_A;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            FETCH_A, FETCH_B: begin
                if (!src_empty) begin
                    src_pop_n      = 1'b0;
                    remaining_next = remaining_dec_s;
                    if (state_r == FETCH_A) begin
                        sort_a_next = src_data;
                        state_next  = FETCH_B;
                    end else begin
                        sort_b_next = src_data;
                        state_next  = WAIT_ROOM;
                    end
                end else begin
                    state_next = state_r;
                end
            end
            WAIT_ROOM: begin
                // The sorter cannot stall, so both result slots must be free first.
                if (dst_room2) begin
                    state_next = START;
                end else begin
                    state_next = WAIT_ROOM;
                end
            end
            START: begin
                state_next = DRAIN1;
            end
            DRAIN1, DRAIN2: begin
                if (!sort_push_n) begin
                    dst_push_n = 1'b0;
                    dst_data   = sort_data;
                end else begin
                    err_next = 1'b1;
                end
                if (state_r == DRAIN1) begin
                    state_next = DRAIN2;
                end else if (remaining_r >= LEN_W'(2)) begin
                    state_next = FETCH_A;
                end else if (remaining_r == LEN_W'(1)) begin
                    state_next = TAIL;
                end else begin
                    state_next = DONE;
                end
            end
            TAIL: begin
                if (!src_empty && dst_room2) begin
                    tail_pop_s     = 1'b1;
                    src_pop_n      = 1'b0;
                    dst_push_n     = 1'b0;
                    dst_data       = src_data;
                    remaining_next = '0;
                    state_next     = DONE;
                end else begin
                    state_next = TAIL;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A sorter push outside the drain window is a protocol violation and is dropped.
        if (!sort_push_n && (state_r != DRAIN1) && (state_r != DRAIN2)) begin
            err_next = 1'b1;
        end else begin
            err_next = err_next;
        end
    end

    // State, operands, counter and status flags; flags are aligned with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            remaining_r  <= '0;
            sort_a_r     <= '0;
            sort_b_r     <= '0;
            err_r        <= 1'b0;
            sort_start_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next;
            remaining_r  <= remaining_next;
            sort_a_r     <= sort_a_next;
            sort_b_r     <= sort_b_next;
            err_r        <= err_next;
            sort_start_r <= (state_next == START);
            busy_r       <= (state_next != IDLE);
            done_r       <= (state_next == DONE);
        end
    end

    assign sort_start = sort_start_r;
    assign sort_a     = sort_a_r;
    assign sort_b     = sort_b_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

`ifdef PAIR_SORT_STATS_EN
    logic [LEN_W-1:0] pair_cnt_r;
    logic             tail_seen_r;

    // Per-job statistics, cleared when a new job is accepted and held after it ends.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pair_cnt_r  <= '0;
            tail_seen_r <= 1'b0;
        end else if (go_accept_s) begin
            pair_cnt_r  <= '0;
            tail_seen_r <= 1'b0;
        end else begin
            if (state_r == DRAIN2) begin
                pair_cnt_r <= pair_cnt_r + LEN_W'(1);
            end
            if (tail_pop_s) begin
                tail_seen_r <= 1'b1;
            end
        end
    end

    assign pair_cnt  = pair_cnt_r;
    assign tail_seen = tail_seen_r;
`endif

endmodule
